// File: rtl/dual_issue_inst_buffer.sv
// Dual-issue instruction buffer: circular FIFO between fetch and issue.
// Accepts up to two instructions per cycle (compacted in program order),
// presents the two oldest entries, and releases one or two per cycle.
module dual_issue_inst_buffer #(
    parameter int DEPTH  = 8,
    parameter int INST_W = 32,
    parameter int PC_W   = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     in_valid_0,
    input  logic [INST_W-1:0]        in_inst_0,
    input  logic [PC_W-1:0]          in_pc_0,
    input  logic                     in_valid_1,
    input  logic [INST_W-1:0]        in_inst_1,
    input  logic [PC_W-1:0]          in_pc_1,
    output logic                     in_ready,
    output logic                     out_valid_0,
    output logic [INST_W-1:0]        out_inst_0,
    output logic [PC_W-1:0]          out_pc_0,
    output logic                     out_valid_1,
    output logic [INST_W-1:0]        out_inst_1,
    output logic [PC_W-1:0]          out_pc_1,
    input  logic                     pop,
    input  logic                     two_issue,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INST_W-1:0] inst_q [DEPTH];
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [AW-1:0]     head1, tail1, wr1_idx;
    logic [CW-1:0]     count_q, count_d, push_n, pop_n;
    logic              acc;

    // Readiness looks only at the registered count: a pair must always fit.
    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign acc      = in_ready & ~flush;
    assign push_n   = acc ? (CW'(in_valid_0) + CW'(in_valid_1)) : '0;

    assign out_valid_0 = (count_q != '0);
    assign out_valid_1 = (count_q >= CW'(2));
    // two_issue with a single valid entry still only releases one.
    assign pop_n = (pop & out_valid_0) ? ((two_issue & out_valid_1) ? CW'(2) : CW'(1)) : '0;

    assign head1   = head_q + AW'(1);
    assign tail1   = tail_q + AW'(1);
    // A lone slot-1 instruction lands at tail, keeping storage compacted.
    assign wr1_idx = in_valid_0 ? tail1 : tail_q;

    assign out_inst_0 = inst_q[head_q];
    assign out_pc_0   = pc_q[head_q];
    assign out_inst_1 = inst_q[head1];
    assign out_pc_1   = pc_q[head1];
    assign count      = count_q;

    // Next-state pointers and occupancy; flush discards same-cycle push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + pop_n[AW-1:0];
            tail_d  = tail_q + push_n[AW-1:0];
            count_d = count_q + push_n - pop_n;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; writes at the old tail, untouched by flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (acc) begin
            if (in_valid_0) begin
                inst_q[tail_q] <= in_inst_0;
                pc_q[tail_q]   <= in_pc_0;
            end
            if (in_valid_1) begin
                inst_q[wr1_idx] <= in_inst_1;
                pc_q[wr1_idx]   <= in_pc_1;
            end
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
        count_q <= CW'(DEPTH));
    a_ptr_consistent: assert property (@(posedge clk) disable iff (!rstn)
        tail_q == AW'(head_q + count_q[AW-1:0]));
`endif

endmodule

// File: tb/tb_dual_issue_inst_buffer.sv
// Scoreboard bench for dual_issue_inst_buffer: the driver pushes expected
// entries into a queue as the buffer accepts them; a negedge monitor compares
// the presented head entries and occupancy, then retires what issue consumes.
module tb_dual_issue_inst_buffer;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn, flush, pop, two_issue;
    logic        in_valid_0, in_valid_1;
    logic [31:0] in_inst_0, in_pc_0, in_inst_1, in_pc_1;
    logic        in_ready, out_valid_0, out_valid_1;
    logic [31:0] out_inst_0, out_pc_0, out_inst_1, out_pc_1;
    logic [3:0]  count;

    int   checks = 0;
    int   failures = 0;
    ent_t q[$];

    dual_issue_inst_buffer #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid_0(in_valid_0), .in_inst_0(in_inst_0), .in_pc_0(in_pc_0),
        .in_valid_1(in_valid_1), .in_inst_1(in_inst_1), .in_pc_1(in_pc_1),
        .in_ready(in_ready),
        .out_valid_0(out_valid_0), .out_inst_0(out_inst_0), .out_pc_0(out_pc_0),
        .out_valid_1(out_valid_1), .out_inst_1(out_inst_1), .out_pc_1(out_pc_1),
        .pop(pop), .two_issue(two_issue), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    // Monitor: compare presented outputs against the scoreboard, retire pops.
    always @(negedge clk) begin
        if (rstn) begin
            automatic int sz = q.size();
            automatic int n = 0;
            chk("mon_count", 32'(count), 32'(sz));
            chk("mon_valid0", 32'(out_valid_0), 32'(sz >= 1));
            chk("mon_valid1", 32'(out_valid_1), 32'(sz >= 2));
            chk("mon_ready", 32'(in_ready), 32'(sz <= DEPTH - 2));
            if (sz >= 1) begin
                chk("mon_pc0", out_pc_0, q[0].pc);
                chk("mon_inst0", out_inst_0, q[0].inst);
            end
            if (sz >= 2) begin
                chk("mon_pc1", out_pc_1, q[1].pc);
                chk("mon_inst1", out_inst_1, q[1].inst);
            end
            if (pop && !flush && sz >= 1) n = (two_issue && sz >= 2) ? 2 : 1;
            repeat (n) void'(q.pop_front());
        end
    end

    // One cycle of stimulus; the scoreboard is updated after the edge commits.
    task automatic cyc(input logic v0, input logic [31:0] p0, input logic [31:0] i0,
                       input logic v1, input logic [31:0] p1, input logic [31:0] i1,
                       input logic pp, input logic two, input logic fl);
        automatic bit acc = !fl && (q.size() <= DEPTH - 2);
        in_valid_0 = v0; in_pc_0 = p0; in_inst_0 = i0;
        in_valid_1 = v1; in_pc_1 = p1; in_inst_1 = i1;
        pop = pp; two_issue = two; flush = fl;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else if (acc) begin
            if (v0) q.push_back('{pc: p0, inst: i0});
            if (v1) q.push_back('{pc: p1, inst: i1});
        end
        in_valid_0 = 0; in_valid_1 = 0; pop = 0; two_issue = 0; flush = 0;
    endtask

    task automatic idle();       cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic push2(input logic [31:0] p); cyc(1, p, ins(p), 1, p + 4, ins(p + 4), 0, 0, 0); endtask
    task automatic push1(input logic [31:0] p); cyc(1, p, ins(p), 0, 0, 0, 0, 0, 0); endtask
    task automatic pop1();       cyc(0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic pop2();       cyc(0, 0, 0, 0, 0, 0, 1, 1, 0); endtask

    initial begin
        rstn = 0; flush = 0; pop = 0; two_issue = 0;
        in_valid_0 = 0; in_valid_1 = 0;
        in_pc_0 = 0; in_inst_0 = 0; in_pc_1 = 0; in_inst_1 = 0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_valid0", 32'(out_valid_0), 0);
        chk("rst_inst0", out_inst_0, 0);
        rstn = 1;
        idle();
        chk("idle_count", 32'(count), 0);
        chk("idle_valid1", 32'(out_valid_1), 0);

        // Pair push, dual pop
        cyc(1, 32'h100, 32'h00A00093, 1, 32'h104, 32'h00100113, 0, 0, 0);
        chk("pair_count", 32'(count), 2);
        chk("pair_pc0", out_pc_0, 32'h100);
        chk("pair_pc1", out_pc_1, 32'h104);
        chk("pair_inst0", out_inst_0, 32'h00A00093);
        chk("pair_inst1", out_inst_1, 32'h00100113);
        pop2();
        chk("dualpop_count", 32'(count), 0);

        // Single issue
        push2(32'h200);
        push1(32'h208);
        chk("si_count", 32'(count), 3);
        chk("si_head0", out_pc_0, 32'h200);
        pop1();
        chk("si_head1", out_pc_0, 32'h204);
        pop1();
        chk("si_head2", out_pc_0, 32'h208);
        chk("si_valid1_low", 32'(out_valid_1), 0);
        pop1();
        chk("si_empty", 32'(count), 0);

        // Lone slot-1 push
        cyc(0, 32'hDEAD, 0, 1, 32'h300, ins(32'h300), 0, 0, 0);
        chk("lone_count", 32'(count), 1);
        chk("lone_pc0", out_pc_0, 32'h300);
        pop2();
        chk("lone_two_pops_one", 32'(count), 0);

        // Fill and wrap (flush first so indices start at 0)
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        push2(32'h500); push2(32'h508); push2(32'h510);
        chk("fill_count6", 32'(count), 6);
        chk("fill_ready6", 32'(in_ready), 1);
        pop2(); pop2();
        push2(32'h518); push2(32'h520); push2(32'h528);
        chk("fill_count8", 32'(count), 8);
        chk("fill_ready8", 32'(in_ready), 0);
        push2(32'h530);
        chk("full_drop", 32'(count), 8);
        pop1();
        chk("fill_count7", 32'(count), 7);
        chk("fill_ready7", 32'(in_ready), 0);
        chk("fill_head7", out_pc_0, 32'h514);
        push1(32'h540);
        chk("single_drop", 32'(count), 7);
        pop2(); pop2();
        chk("wrap_head", out_pc_0, 32'h524);
        chk("wrap_head1", out_pc_1, 32'h528);
        pop2(); pop2();
        chk("drain_count", 32'(count), 0);

        // Flush with simultaneous push and pop
        push2(32'h600); push2(32'h608); push1(32'h610);
        chk("fl_count5", 32'(count), 5);
        cyc(1, 32'h700, ins(32'h700), 1, 32'h704, ins(32'h704), 1, 1, 1);
        chk("fl_count0", 32'(count), 0);
        chk("fl_valid0", 32'(out_valid_0), 0);
        push1(32'h400);
        chk("fl_push_count", 32'(count), 1);
        chk("fl_push_head", out_pc_0, 32'h400);

        // Async reset mid-traffic
        push2(32'h800); push1(32'h808);
        chk("ar_count4", 32'(count), 4);
        #2;
        rstn = 0;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_valid0", 32'(out_valid_0), 0);
        chk("ar_ready", 32'(in_ready), 1);
        q.delete();
        @(posedge clk);
        #1;
        rstn = 1;
        idle();
        chk("ar_after_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_issue_inst_buffer.md
Name: dual_issue_inst_buffer

Overview:
- Instruction buffer between the fetch stage and the dual-issue decode/issue stage.
- Accepts up to two fetched instructions per cycle, with their PCs.
- Presents the two oldest instructions to the issue logic, which consumes them.
- Releases one or two entries per cycle according to the two-issue decision, and flushes on redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- INST_W, 32, instruction width.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  redirect/mispredict; empties the buffer.
- in_valid_0  in  1  fetch slot 0 valid (older).
- in_inst_0  in  INST_W  fetch slot 0 instruction.
- in_pc_0  in  PC_W  fetch slot 0 PC.
- in_valid_1  in  1  fetch slot 1 valid (younger).
- in_inst_1  in  INST_W  fetch slot 1 instruction.
- in_pc_1  in  PC_W  fetch slot 1 PC.
- in_ready  out  1  buffer can accept a full pair this cycle.
- out_valid_0  out  1  head entry valid.
- out_inst_0  out  INST_W  head instruction.
- out_pc_0  out  PC_W  head PC.
- out_valid_1  out  1  head+1 entry valid.
- out_inst_1  out  INST_W  head+1 instruction.
- out_pc_1  out  PC_W  head+1 PC.
- pop  in  1  issue stage consumes this cycle (stall = 0).
- two_issue  in  1  issue decision: consume head and head+1.
- count  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- State:
  - storage array of DEPTH entries {pc, inst}.
  - head and tail pointers, log2(DEPTH) bits each, wrap modulo DEPTH.
  - registered count.
- Reset (rstn low, asynchronous):
  - head, tail and count go to 0; storage clears to 0.
  - Outputs during and after reset: out_valid_0 = 0, out_valid_1 = 0, count = 0, in_ready = 1, out_inst_* = 0, out_pc_* = 0.
- in_ready = (DEPTH - count) >= 2. Computed from the registered count only, with no same-cycle pop forwarding.
- Push:
  - Accepted only when in_ready = 1.
  - push_n = in_valid_0 + in_valid_1.
  - Entries are written compacted in program order: slot 0 first, then slot 1. If only in_valid_1 is set, it is written at tail.
  - tail advances by push_n.
  - When in_ready = 0, both slots are dropped. Fetch must hold and replay them.
- Outputs:
  - out_valid_0 = (count >= 1); out_valid_1 = (count >= 2).
  - out_inst_0 and out_pc_0 read storage[head]; out_inst_1 and out_pc_1 read storage[head+1 mod DEPTH]. Both are combinational reads.
  - Data on an invalid slot is don't-care.
- Latency: an instruction pushed in cycle N is visible on the outputs in cycle N+1, at the earliest.
- Pop:
  - pop_n = 0 if pop = 0 or out_valid_0 = 0.
  - Otherwise pop_n = 1 + (two_issue & out_valid_1).
  - two_issue with only one valid entry pops exactly 1.
  - head advances by pop_n.
- Simultaneous push and pop: count_next = count + push_n - pop_n. Push writes at the old tail, pop reads at the old head. No bypass from input to output in the same cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH. A pair written at tail = DEPTH-1 places slot 1 at index 0. A pop of 2 at head = DEPTH-1 yields head = 1.
- Flush:
  - Highest priority after reset. Next cycle head = tail = count = 0.
  - Same-cycle push and pop are discarded. Storage contents are left unchanged.
- Full and empty:
  - count never exceeds DEPTH and never underflows; a push is only accepted with at least 2 free entries.
  - With DEPTH-1 entries occupied, in_ready = 0 even for a single-slot push.
- Simulation assertions: count <= DEPTH; tail == (head + count) mod DEPTH.

Test Plan:
- Reset then idle:
  - Stimulus: rstn low for 2 cycles, then high, with no traffic.
  - Required: count = 0, out_valid_0 = 0, out_valid_1 = 0, in_ready = 1.
- Pair push, dual pop:
  - Stimulus: push pc 0x100/0x104 with inst 0x00A00093/0x00100113, and pop = 0. Next cycle, pop = 1 with two_issue = 1.
  - Required: the cycle after the push shows out_pc_0 = 0x100, out_pc_1 = 0x104, count = 2. After the pop, count = 0.
- Single issue:
  - Stimulus: 3 entries buffered (0x200, 0x204, 0x208); pop = 1, two_issue = 0 for 3 cycles.
  - Required: heads 0x200, 0x204, 0x208 in order; out_valid_1 falls when count = 1.
- Lone slot-1 push:
  - Stimulus: in_valid_0 = 0, in_valid_1 = 1, pc 0x300.
  - Required: count = 1, out_pc_0 = 0x300.
- Fill and wrap:
  - Stimulus: push 3 pairs; pop 2 twice; push 3 more pairs with DEPTH = 8.
  - Required: in_ready drops when count = 7 or 8; output order is preserved across index 7→0; count never exceeds 8.
- Flush:
  - Stimulus: count = 5; flush = 1 with a simultaneous push and pop.
  - Required: count = 0 next cycle, out_valid_0 = 0; a following push of 0x400 appears at the head.
- Async reset mid-traffic:
  - Stimulus: drop rstn while count = 4, between clock edges.
  - Required: count = 0 and out_valid_0 = 0 immediately, without waiting for a clock edge.
